// File: rtl/mux2x1_16bit_arbiter.sv
// Round-robin arbiter sharing one 2:1 mux datapath between two requesters.
// The selected word is registered into a single-entry output slot and
// offered downstream through a valid/ready handshake.
//
// Ports:
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   req0/din0/gnt0    requester 0: request, data, combinational grant
//   req1/din1/gnt1    requester 1: request, data, combinational grant
//   sel               registered mux select (last granted requester)
//   dout/dout_valid   registered output word and its valid flag
//   dout_ready        consumer accepts dout when dout_valid & dout_ready
//   cnt0/cnt1         wrapping grant counters per requester
module mux2x1_16bit_arbiter #(
  parameter int unsigned WIDTH         = 16,
  parameter bit          PRIORITY_INIT = 1'b0,
  parameter int unsigned CNT_WIDTH     = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req0,
  input  logic [WIDTH-1:0]     din0,
  output logic                 gnt0,
  input  logic                 req1,
  input  logic [WIDTH-1:0]     din1,
  output logic                 gnt1,
  output logic                 sel,
  output logic [WIDTH-1:0]     dout,
  output logic                 dout_valid,
  input  logic                 dout_ready,
  output logic [CNT_WIDTH-1:0] cnt0,
  output logic [CNT_WIDTH-1:0] cnt1
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_e;

  state_e               state_q, state_d;
  logic                 prio_q, prio_d;
  logic                 sel_q, sel_d;
  logic [WIDTH-1:0]     dout_q, dout_d;
  logic [CNT_WIDTH-1:0] cnt0_q, cnt0_d;
  logic [CNT_WIDTH-1:0] cnt1_q, cnt1_d;

  logic slot_free;
  logic choice;
  logic gnt0_c, gnt1_c;

  always_comb begin
    // A FULL slot is free when its word is being consumed this cycle.
    slot_free = (state_q == EMPTY) || dout_ready;
    // With a single requester, req1 alone names the winner.
    choice    = (req0 && req1) ? prio_q : req1;
    // Grants are gated by rst_n so none is issued while reset is held.
    gnt0_c    = rst_n && slot_free && req0 && !choice;
    gnt1_c    = rst_n && slot_free && req1 && choice;

    state_d = state_q;
    prio_d  = prio_q;
    sel_d   = sel_q;
    dout_d  = dout_q;
    cnt0_d  = cnt0_q;
    cnt1_d  = cnt1_q;

    if (gnt0_c) begin
      dout_d  = din0;
      sel_d   = 1'b0;
      prio_d  = 1'b1;
      cnt0_d  = cnt0_q + CNT_WIDTH'(1);
      state_d = FULL;
    end else if (gnt1_c) begin
      dout_d  = din1;
      sel_d   = 1'b1;
      prio_d  = 1'b0;
      cnt1_d  = cnt1_q + CNT_WIDTH'(1);
      state_d = FULL;
    end else if (state_q == FULL && dout_ready) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      prio_q  <= PRIORITY_INIT;
      sel_q   <= 1'b0;
      dout_q  <= '0;
      cnt0_q  <= '0;
      cnt1_q  <= '0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      sel_q   <= sel_d;
      dout_q  <= dout_d;
      cnt0_q  <= cnt0_d;
      cnt1_q  <= cnt1_d;
    end
  end

  assign gnt0       = gnt0_c;
  assign gnt1       = gnt1_c;
  assign sel        = sel_q;
  assign dout       = dout_q;
  assign dout_valid = (state_q == FULL);
  assign cnt0       = cnt0_q;
  assign cnt1       = cnt1_q;

endmodule

// File: tb/tb_mux2x1_16bit_arbiter.sv
// Bench for mux2x1_16bit_arbiter: two instances (priority after reset 0 and 1,
// 4-bit counters) run side by side, each with its own requesters, against a
// behavioural model of the output slot, turn pointer and grant counts.
module tb_mux2x1_16bit_arbiter;
  localparam int W  = 16;
  localparam int CW = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req0[2], req1[2], rdy[2];
  logic [W-1:0] din0[2], din1[2];
  logic         gnt0[2], gnt1[2], sel[2], vld[2];
  logic [W-1:0] dout[2];
  logic [CW-1:0] cnt0[2], cnt1[2];

  always #5 clk = ~clk;

  mux2x1_16bit_arbiter #(.WIDTH(W), .PRIORITY_INIT(1'b0), .CNT_WIDTH(CW)) u_a (
    .clk(clk), .rst_n(rst_n),
    .req0(req0[0]), .din0(din0[0]), .gnt0(gnt0[0]),
    .req1(req1[0]), .din1(din1[0]), .gnt1(gnt1[0]),
    .sel(sel[0]), .dout(dout[0]), .dout_valid(vld[0]), .dout_ready(rdy[0]),
    .cnt0(cnt0[0]), .cnt1(cnt1[0]));

  mux2x1_16bit_arbiter #(.WIDTH(W), .PRIORITY_INIT(1'b1), .CNT_WIDTH(CW)) u_b (
    .clk(clk), .rst_n(rst_n),
    .req0(req0[1]), .din0(din0[1]), .gnt0(gnt0[1]),
    .req1(req1[1]), .din1(din1[1]), .gnt1(gnt1[1]),
    .sel(sel[1]), .dout(dout[1]), .dout_valid(vld[1]), .dout_ready(rdy[1]),
    .cnt0(cnt0[1]), .cnt1(cnt1[1]));

  int checks = 0;
  int errors = 0;

  // Model: slot contents, whose turn it is on a tie, grant totals.
  int m_valid[2], m_dout[2], m_sel[2], m_turn[2], m_cnt[2][2];
  int eg[2][2];

  task automatic chk(input string nm, input int k, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[inst %0d]: got %0d expected %0d at %0t", nm, k, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_valid[k] = 0; m_dout[k] = 0; m_sel[k] = 0; m_turn[k] = k;
      m_cnt[k][0] = 0; m_cnt[k][1] = 0;
    end
  endtask

  // One clock cycle: called just after a falling edge with inputs applied.
  task automatic cycle();
    int r[2];
    int winner;
    #1;
    for (int k = 0; k < 2; k++) begin
      r[0] = int'(req0[k]); r[1] = int'(req1[k]);
      winner = -1;
      // Round-robin search starting from whoever holds the turn.
      if (!m_valid[k] || rdy[k])
        for (int s = 0; s < 2; s++)
          if (winner < 0 && r[(m_turn[k] + s) % 2] == 1) winner = (m_turn[k] + s) % 2;
      eg[k][0] = (winner == 0); eg[k][1] = (winner == 1);
      chk("gnt0", k, gnt0[k], eg[k][0]);
      chk("gnt1", k, gnt1[k], eg[k][1]);
      chk("dout_valid", k, vld[k], m_valid[k]);
      chk("dout", k, dout[k], m_dout[k]);
      chk("sel", k, sel[k], m_sel[k]);
      chk("cnt0", k, cnt0[k], m_cnt[k][0]);
      chk("cnt1", k, cnt1[k], m_cnt[k][1]);
    end
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (eg[k][0] || eg[k][1]) begin
        winner = eg[k][1];
        m_dout[k]  = winner ? int'(din1[k]) : int'(din0[k]);
        m_valid[k] = 1;
        m_sel[k]   = winner;
        m_turn[k]  = 1 - winner;
        m_cnt[k][winner] = (m_cnt[k][winner] + 1) % (1 << CW);
      end else if (m_valid[k] && rdy[k]) begin
        m_valid[k] = 0;
      end
    end
    @(negedge clk);
  endtask

  // Asserts reset mid-cycle and checks outputs clear with no clock edge.
  task automatic do_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("rst_valid", k, vld[k], 0);
      chk("rst_dout", k, dout[k], 0);
      chk("rst_sel", k, sel[k], 0);
      chk("rst_cnt0", k, cnt0[k], 0);
      chk("rst_cnt1", k, cnt1[k], 0);
      chk("rst_gnt", k, {gnt1[k], gnt0[k]}, 0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic set_all(input logic r0, input logic [W-1:0] d0, input logic r1,
                         input logic [W-1:0] d1, input logic rd);
    for (int k = 0; k < 2; k++) begin
      req0[k] = r0; din0[k] = d0; req1[k] = r1; din1[k] = d1; rdy[k] = rd;
    end
  endtask

  int exp_a[4] = '{25, 1000, 25, 1000};

  initial begin
    rst_n = 1'b0;
    set_all(1'b0, '0, 1'b0, '0, 1'b0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Lone requester 0: grant, capture, then slot drains.
    set_all(1'b1, 16'd25, 1'b0, 16'd0, 1'b1);
    #1 chk("lit_gnt0_first", 0, gnt0[0], 1);
    cycle();
    chk("lit_dout25", 0, dout[0], 25);
    chk("lit_valid1", 0, vld[0], 1);
    chk("lit_cnt0_1", 0, cnt0[0], 1);
    set_all(1'b0, 16'd25, 1'b0, 16'd0, 1'b1);
    cycle();
    chk("lit_valid0", 0, vld[0], 0);

    // Both requesting from reset: strict alternation starting at PRIORITY_INIT.
    do_reset();
    set_all(1'b1, 16'd25, 1'b1, 16'd1000, 1'b1);
    for (int i = 0; i < 4; i++) begin
      cycle();
      chk("lit_alt_dout_a", 0, dout[0], exp_a[i]);
      chk("lit_alt_sel_a", 0, sel[0], i % 2);
      chk("lit_alt_dout_b", 1, dout[1], exp_a[(i + 1) % 4]);
      chk("lit_alt_sel_b", 1, sel[1], (i + 1) % 2);
    end
    chk("lit_cnt0_2", 0, cnt0[0], 2);
    chk("lit_cnt1_2", 0, cnt1[0], 2);

    // Backpressure: slot full, consumer stalled, requester 1 waits.
    set_all(1'b0, 16'd25, 1'b1, 16'd777, 1'b0);
    for (int i = 0; i < 5; i++) begin
      #1 chk("lit_bp_gnt1", 0, gnt1[0], 0);
      cycle();
      chk("lit_bp_dout", 0, dout[0], 1000);
      chk("lit_bp_cnt1", 0, cnt1[0], 2);
    end
    for (int k = 0; k < 2; k++) rdy[k] = 1'b1;
    #1 chk("lit_bp_release", 0, gnt1[0], 1);
    cycle();
    chk("lit_bp_dout777", 0, dout[0], 777);
    chk("lit_bp_cnt1_3", 0, cnt1[0], 3);

    // Mid-stream reset with requests pending, then restart from PRIORITY_INIT.
    set_all(1'b1, 16'd25, 1'b1, 16'd1000, 1'b1);
    do_reset();
    #1 chk("lit_restart_a", 0, gnt0[0], 1);
    chk("lit_restart_b", 1, gnt1[1], 1);
    cycle();
    chk("lit_restart_dout_b", 1, dout[1], 1000);

    // Counter wrap: 17 grants to requester 0 alone.
    do_reset();
    set_all(1'b1, 16'd5, 1'b0, 16'd0, 1'b1);
    for (int i = 0; i < 17; i++) begin
      for (int k = 0; k < 2; k++) din0[k] = 16'($urandom);
      cycle();
    end
    chk("lit_wrap_cnt0", 0, cnt0[0], 1);
    chk("lit_wrap_cnt1", 0, cnt1[0], 0);

    // Random traffic with random backpressure and occasional resets.
    do_reset();
    set_all(1'b0, '0, 1'b0, '0, 1'b1);
    for (int i = 0; i < 3000; i++) begin
      cycle();
      if ($urandom_range(0, 499) == 0) do_reset();
      for (int k = 0; k < 2; k++) begin
        if (!req0[k] || eg[k][0] == 1) begin
          req0[k] = ($urandom_range(0, 3) != 0);
          din0[k] = 16'($urandom);
        end
        if (!req1[k] || eg[k][1] == 1) begin
          req1[k] = ($urandom_range(0, 3) != 0);
          din1[k] = 16'($urandom);
        end
        rdy[k] = ($urandom_range(0, 9) < 7);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
